// File: rtl/syn_fifo_thresh_if.sv
// ----------------------------------------------------------------------------
// syn_fifo_thresh_if
// Producer/consumer-side bundle for syn_fifo_thresh.
//   master : the block that drives writes/reads and observes FIFO status
//   slave  : the FIFO itself
// Signals:
//   clear        flush request (master -> slave)
//   wr_en/data_in  write request and data (master -> slave)
//   rd_en        read request / FWFT head acknowledge (master -> slave)
//   data_out, data_valid                     read data path (slave -> master)
//   full, empty, almost_full, almost_empty   occupancy flags (slave -> master)
//   level        occupancy count, 0..2**ADDR_WIDTH (slave -> master)
//   overflow, underflow  one-cycle rejected-request pulses (slave -> master)
// ----------------------------------------------------------------------------
interface syn_fifo_thresh_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, data_in, rd_en,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_thresh.sv
// ----------------------------------------------------------------------------
// syn_fifo_thresh
// Single-clock FIFO with register-array storage, programmable almost-full /
// almost-empty thresholds, occupancy count, overflow/underflow pulses,
// synchronous flush and selectable standard / first-word-fall-through read.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    syn_fifo_thresh_if.slave (write, read, flags, level, error pulses)
// ----------------------------------------------------------------------------
module syn_fifo_thresh #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = 14,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    syn_fifo_thresh_if.slave    bus
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LVL_W = ADDR_WIDTH + 1;

    // Threshold sanity: almost_empty region must sit strictly below almost_full.
    if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH >= 1) &&
          (AFULL_THRESH <= DEPTH))) begin : g_bad_thresh
        $error("syn_fifo_thresh: require AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_nxt_c;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  full_c;
    logic                  empty_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    // Status flags derive from the registered level only.
    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);

    // Flush wins over both requests in its cycle.
    assign wr_acc_c = bus.wr_en & ~full_c  & ~bus.clear;
    assign rd_acc_c = bus.rd_en & ~empty_c & ~bus.clear;

    // Occupancy next-state: simultaneous accepted read+write cancels out.
    always_comb begin
        level_nxt_c = level_q;
        if (bus.clear) begin
            level_nxt_c = '0;
        end else begin
            case ({wr_acc_c, rd_acc_c})
                2'b10:   level_nxt_c = level_q + LVL_W'(1);
                2'b01:   level_nxt_c = level_q - LVL_W'(1);
                default: level_nxt_c = level_q;
            endcase
        end
    end

    // Storage array; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, level and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            level_q     <= level_nxt_c;
            overflow_q  <= bus.wr_en & full_c;
            underflow_q <= bus.rd_en & empty_c;
        end
    end

    // Read data path.
    if (FWFT == 0) begin : g_std_read
        logic [DATA_WIDTH-1:0] data_out_q;
        logic                  data_valid_q;

        // Registered read: word appears one cycle after an accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_out_q   <= '0;
                data_valid_q <= 1'b0;
            end else if (bus.clear) begin
                data_valid_q <= 1'b0;
            end else if (rd_acc_c) begin
                data_out_q   <= mem[rd_ptr];
                data_valid_q <= 1'b1;
            end else begin
                data_valid_q <= 1'b0;
            end
        end

        assign bus.data_out   = data_out_q;
        assign bus.data_valid = data_valid_q;
    end else begin : g_fwft_read
        // Head word is always presented; rd_en acknowledges and advances.
        assign bus.data_out   = mem[rd_ptr];
        assign bus.data_valid = ~empty_c;
    end

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (level_q >= LVL_W'(AFULL_THRESH));
    assign bus.almost_empty = (level_q <= LVL_W'(AEMPTY_THRESH));
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
